operand_streamer: RTL

// Write-side producer for the computing_unit operand queues. Fetches weight, activation and offset

---
 rtl/operand_streamer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/operand_streamer.sv
// Write-side producer for the computing_unit operand FIFOs: fetches weight, activation and offset
// vectors from a 1-cycle-latency vector memory and sequences them tile by tile into the FIFOs.
module operand_streamer #(
  parameter int SYSTOL_ACTIVATION_COUNT = 16,
  parameter int SYSTOL_WEIGHT_COUNT     = 16,
  parameter int ADDR_W                  = 16,
  parameter int LEN_W                   = 16,
  parameter int DATA_W                  = 8,
  localparam int MEM_LANES = (SYSTOL_ACTIVATION_COUNT > SYSTOL_WEIGHT_COUNT) ?
                             SYSTOL_ACTIVATION_COUNT : SYSTOL_WEIGHT_COUNT
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          start_i,
  input  logic [LEN_W-1:0]                              tile_count_i,
  input  logic [LEN_W-1:0]                              act_len_i,
  input  logic [ADDR_W-1:0]                             w_base_i,
  input  logic [ADDR_W-1:0]                             act_base_i,
  input  logic [ADDR_W-1:0]                             off_base_i,
  output logic                                          busy_o,
  output logic                                          done_o,
  output logic                                          mem_rd_en_o,
  output logic [ADDR_W-1:0]                             mem_addr_o,
  input  logic [MEM_LANES-1:0][DATA_W-1:0]              mem_rdata_i,
  input  logic                                          cu_rst_busy_i,
  input  logic                                          cu_wupd_busy_i,
  input  logic                                          tile_drained_i,
  output logic [SYSTOL_WEIGHT_COUNT-1:0][DATA_W-1:0]    weight_o,
  output logic                                          weight_wr_en_o,
  input  logic                                          weight_full_i,
  output logic [SYSTOL_ACTIVATION_COUNT-1:0][DATA_W-1:0] activation_o,
  output logic                                          activation_wr_en_o,
  input  logic                                          activation_full_i,
  output logic [SYSTOL_WEIGHT_COUNT-1:0][DATA_W-1:0]    offset_o,
  output logic                                          offset_wr_en_o,
  input  logic                                          offset_full_i,
  output logic                                          weight_update_o
);
  localparam int SA  = SYSTOL_ACTIVATION_COUNT;
  localparam int SW  = SYSTOL_WEIGHT_COUNT;
  localparam int WCW = $clog2(SA) + 1;

  typedef enum logic [2:0] {IDLE, WAIT_RDY, LOAD_W, WAIT_DRAIN, UPDATE, STREAM, DONE} state_t;
  typedef enum logic [1:0] {TAG_W, TAG_A, TAG_O} tag_t;
  typedef struct packed {
    tag_t                               tag;
    logic [MEM_LANES-1:0][DATA_W-1:0]   data;
  } entry_t;

  state_t             state;
  logic [LEN_W-1:0]   tiles_q, tile_idx, act_len_q;
  logic [ADDR_W-1:0]  w_ptr, a_ptr, o_ptr;
  logic               first_tile;
  logic [WCW-1:0]     w_iss, w_wr;
  logic [LEN_W:0]     s_iss, s_wr;

  logic               inflight_q;
  tag_t               inflight_tag_q;
  entry_t             sb [2];
  logic               sb_head;
  logic [1:0]         sb_cnt;

  entry_t             head;
  logic               wr_ok, pop, pop_s, issue, room, w_need, s_need, w_done, s_done;
  logic [1:0]         occ;
  tag_t               iss_tag;

  // Write side: only the head of the skid buffer may be written, so fetch order is kept.
  assign head               = sb[sb_head];
  assign wr_ok              = (sb_cnt != 2'd0) && !cu_rst_busy_i;
  assign weight_wr_en_o     = wr_ok && (head.tag == TAG_W) && !weight_full_i;
  assign activation_wr_en_o = wr_ok && (head.tag == TAG_A) && !activation_full_i;
  assign offset_wr_en_o     = wr_ok && (head.tag == TAG_O) && !offset_full_i;
  assign pop_s              = activation_wr_en_o || offset_wr_en_o;
  assign pop                = weight_wr_en_o || pop_s;
  assign weight_o           = head.data[SW-1:0];
  assign activation_o       = head.data[SA-1:0];
  assign offset_o           = head.data[SW-1:0];

  // Counting the slot freed by this cycle's write keeps 1 vector/cycle with a 2-deep buffer.
  assign occ    = sb_cnt + {1'b0, inflight_q} - {1'b0, pop};
  assign room   = occ < 2'd2;
  assign w_need = (state == LOAD_W) && (w_iss != WCW'(SA));
  assign s_need = (state == STREAM) && (s_iss != {act_len_q, 1'b0});
  assign w_done = (w_wr + WCW'(weight_wr_en_o)) == WCW'(SA);
  assign s_done = (s_wr + (LEN_W+1)'(pop_s)) == {act_len_q, 1'b0};

  always_comb begin
    issue      = 1'b0;
    iss_tag    = TAG_W;
    mem_addr_o = '0;
    if (room && w_need) begin
      issue      = 1'b1;
      mem_addr_o = w_ptr;
    end else if (room && s_need) begin
      issue      = 1'b1;
      iss_tag    = s_iss[0] ? TAG_O : TAG_A;
      mem_addr_o = s_iss[0] ? o_ptr : a_ptr;
    end
  end
  assign mem_rd_en_o = issue;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      inflight_q     <= 1'b0;
      inflight_tag_q <= TAG_W;
      sb_head        <= 1'b0;
      sb_cnt         <= 2'd0;
      for (int i = 0; i < 2; i++) sb[i] <= '0;
    end else begin
      inflight_q     <= issue;
      inflight_tag_q <= iss_tag;
      // With 2 entries a push into a full buffer always coincides with a pop, so the
      // tail lands on the slot being vacated.
      if (inflight_q) sb[sb_head ^ sb_cnt[0]] <= '{tag: inflight_tag_q, data: mem_rdata_i};
      sb_head <= sb_head ^ pop;
      sb_cnt  <= sb_cnt + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state           <= IDLE;
      tiles_q         <= '0;
      tile_idx        <= '0;
      act_len_q       <= '0;
      w_ptr           <= '0;
      a_ptr           <= '0;
      o_ptr           <= '0;
      first_tile      <= 1'b0;
      w_iss           <= '0;
      w_wr            <= '0;
      s_iss           <= '0;
      s_wr            <= '0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      weight_update_o <= 1'b0;
    end else begin
      if (weight_wr_en_o) w_wr <= w_wr + 1'b1;
      if (pop_s)          s_wr <= s_wr + 1'b1;
      if (issue && w_need) begin
        w_iss <= w_iss + 1'b1;
        w_ptr <= w_ptr + 1'b1;
      end else if (issue) begin
        s_iss <= s_iss + 1'b1;
        if (s_iss[0]) o_ptr <= o_ptr + 1'b1;
        else          a_ptr <= a_ptr + 1'b1;
      end
      case (state)
        IDLE: if (start_i) begin
          tiles_q   <= tile_count_i;
          act_len_q <= act_len_i;
          w_ptr     <= w_base_i;
          a_ptr     <= act_base_i;
          o_ptr     <= off_base_i;
          busy_o    <= 1'b1;
          state     <= WAIT_RDY;
        end
        WAIT_RDY: if (!cu_rst_busy_i) begin
          if (tiles_q == '0) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= DONE;
          end else begin
            tile_idx   <= '0;
            first_tile <= 1'b1;
            w_iss      <= '0;
            w_wr       <= '0;
            state      <= LOAD_W;
          end
        end
        LOAD_W: if (w_done) state <= WAIT_DRAIN;
        // Later tiles hold new weights back until queued activations have been consumed.
        WAIT_DRAIN: if (first_tile || (tile_drained_i && !cu_wupd_busy_i)) begin
          weight_update_o <= 1'b1;
          state           <= UPDATE;
        end
        UPDATE: begin
          weight_update_o <= 1'b0;
          s_iss           <= '0;
          s_wr            <= '0;
          state           <= STREAM;
        end
        STREAM: if (s_done) begin
          if (tile_idx + 1'b1 == tiles_q) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= DONE;
          end else begin
            tile_idx   <= tile_idx + 1'b1;
            first_tile <= 1'b0;
            w_iss      <= '0;
            w_wr       <= '0;
            state      <= LOAD_W;
          end
        end
        DONE: begin
          done_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
